// File: rtl/mp_rf_frontend_pkg.sv
// Shared constants and request types for the 3R3W register-file front-end.
package mp_rf_frontend_pkg;

  localparam int unsigned NUM_R     = 3;
  localparam int unsigned NUM_W     = 3;
  localparam int unsigned W         = 32;
  localparam int unsigned N         = 1024;
  localparam int unsigned AW        = $clog2(N);
  localparam int unsigned RSP_DEPTH = 3;
  localparam int unsigned CRW       = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
  } rd_req_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_req_t;

  typedef logic [CRW-1:0] credit_t;

endpackage

// File: rtl/mp_rf_rsp_fifo.sv
// Small registered response FIFO; head is read straight from the storage flops.
module mp_rf_rsp_fifo #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CntW'(Depth));
  assign do_pop = pop & ~empty;
  assign head   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mp_rf_frontend_3r3w.sv
// Valid/ready front-end for the 3R3W LVT register file: credit-limited read
// responses, write-collision filtering. Define MP_RF_FRONTEND_BYPASS_EN for write-to-read bypass.
module mp_rf_frontend_3r3w
  import mp_rf_frontend_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_R-1:0]    rreq_vld,
  input  logic [NUM_R*AW-1:0] rreq_addr,
  output logic [NUM_R-1:0]    rreq_rdy,
  output logic [NUM_R-1:0]    rrsp_vld,
  output logic [NUM_R*W-1:0]  rrsp_data,
  input  logic [NUM_R-1:0]    rrsp_rdy,
  input  logic [NUM_W-1:0]    wreq_vld,
  input  logic [NUM_W*AW-1:0] wreq_addr,
  input  logic [NUM_W*W-1:0]  wreq_data,
  output logic [NUM_R-1:0]    mem_ren,
  output logic [NUM_R*AW-1:0] mem_raddr,
  input  logic [NUM_R*W-1:0]  mem_rdata,
  output logic [NUM_W-1:0]    mem_wen,
  output logic [NUM_W*AW-1:0] mem_waddr,
  output logic [NUM_W*W-1:0]  mem_wdata,
  output logic [15:0]         wr_coll_cnt
);

  localparam int unsigned SuppW = $clog2(NUM_W + 1);

  rd_req_t [NUM_R-1:0] rd_req;
  wr_req_t [NUM_W-1:0] wr_req;
  logic    [NUM_R-1:0] rd_acc;
  logic    [NUM_W-1:0] wr_supp;
  logic    [SuppW-1:0] n_supp;
  logic    [15:0]      coll_cnt_q;
  logic    [16:0]      coll_sum;

  for (genvar i = 0; i < NUM_W; i++) begin : g_wr
    assign wr_req[i]               = {wreq_addr[i*AW +: AW], wreq_data[i*W +: W]};
    assign mem_waddr[i*AW +: AW]   = wr_req[i].addr;
    assign mem_wdata[i*W +: W]     = wr_req[i].data;
  end

  // A lower-numbered write loses to any higher-numbered write to the same address.
  always_comb begin
    wr_supp = '0;
    n_supp  = '0;
    for (int i = 0; i < NUM_W; i++) begin
      for (int j = i + 1; j < NUM_W; j++) begin
        if (wreq_vld[i] && wreq_vld[j] && (wr_req[i].addr == wr_req[j].addr)) begin
          wr_supp[i] = 1'b1;
        end
      end
      n_supp = n_supp + SuppW'(wr_supp[i]);
    end
  end

  assign mem_wen     = wreq_vld & ~wr_supp & {NUM_W{~rst}};
  assign coll_sum    = {1'b0, coll_cnt_q} + 17'(n_supp);
  assign wr_coll_cnt = coll_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) coll_cnt_q <= '0;
    else     coll_cnt_q <= coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
  end

  for (genvar p = 0; p < NUM_R; p++) begin : g_rd
    credit_t        cr_q, cr_d;
    logic           pend_q, pop, empty, full;
    logic [W-1:0]   push_data, head;

    assign rd_req[p].addr          = rreq_addr[p*AW +: AW];
    assign mem_raddr[p*AW +: AW]   = rd_req[p].addr;
    assign rreq_rdy[p]             = ~rst & (cr_q < credit_t'(RSP_DEPTH));
    assign rd_acc[p]               = rreq_vld[p] & rreq_rdy[p];
    assign mem_ren[p]              = rd_acc[p];
    assign pop                     = rrsp_vld[p] & rrsp_rdy[p];

    // Credits cover both in-flight reads and FIFO occupancy, so the FIFO cannot overflow.
    always_comb begin
      cr_d = cr_q;
      case ({rd_acc[p], pop})
        2'b10:   cr_d = cr_q + credit_t'(1);
        2'b01:   cr_d = cr_q - credit_t'(1);
        default: cr_d = cr_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cr_q   <= '0;
        pend_q <= 1'b0;
      end else begin
        cr_q   <= cr_d;
        pend_q <= rd_acc[p];
      end
    end

`ifdef MP_RF_FRONTEND_BYPASS_EN
    logic         byp_hit_d, byp_hit_q;
    logic [W-1:0] byp_data_d, byp_data_q;

    // Post-collision enables guarantee at most one matching write.
    always_comb begin
      byp_hit_d  = 1'b0;
      byp_data_d = '0;
      for (int i = 0; i < NUM_W; i++) begin
        if (mem_wen[i] && (wr_req[i].addr == rd_req[p].addr)) begin
          byp_hit_d  = 1'b1;
          byp_data_d = wr_req[i].data;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        byp_hit_q  <= 1'b0;
        byp_data_q <= '0;
      end else begin
        byp_hit_q  <= byp_hit_d & rd_acc[p];
        byp_data_q <= byp_data_d;
      end
    end

    assign push_data = byp_hit_q ? byp_data_q : mem_rdata[p*W +: W];
`else
    assign push_data = mem_rdata[p*W +: W];
`endif

    mp_rf_rsp_fifo #(
      .Depth (RSP_DEPTH),
      .Width (W)
    ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pend_q),
      .wdata (push_data),
      .pop   (pop),
      .head  (head),
      .empty (empty),
      .full  (full)
    );

    assign rrsp_vld[p]         = ~empty;
    assign rrsp_data[p*W +: W] = head;

    fifo_no_overflow_a : assert property (@(posedge clk) disable iff (rst) !(pend_q && full));
  end

endmodule

// File: tb/tb_mp_rf_frontend_3r3w.sv
// Directed bench for mp_rf_frontend_3r3w with a flop-based 3R3W memory model attached.
module tb_mp_rf_frontend_3r3w;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rreq_vld, rreq_rdy, rrsp_vld, rrsp_rdy;
  logic [29:0] rreq_addr;
  logic [95:0] rrsp_data;
  logic [2:0]  wreq_vld;
  logic [29:0] wreq_addr;
  logic [95:0] wreq_data;
  logic [2:0]  mem_ren, mem_wen;
  logic [29:0] mem_raddr, mem_waddr;
  logic [95:0] mem_rdata, mem_wdata;
  logic [15:0] wr_coll_cnt;

  int errors = 0;
  int checks = 0;
  int bp_exp [8];

  always #5 clk = ~clk;

  mp_rf_frontend_3r3w dut (
    .clk         (clk),
    .rst         (rst),
    .rreq_vld    (rreq_vld),
    .rreq_addr   (rreq_addr),
    .rreq_rdy    (rreq_rdy),
    .rrsp_vld    (rrsp_vld),
    .rrsp_data   (rrsp_data),
    .rrsp_rdy    (rrsp_rdy),
    .wreq_vld    (wreq_vld),
    .wreq_addr   (wreq_addr),
    .wreq_data   (wreq_data),
    .mem_ren     (mem_ren),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .mem_wen     (mem_wen),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .wr_coll_cnt (wr_coll_cnt)
  );

  // Memory model: synchronous read, write visible to reads from the next cycle.
  logic [31:0] mem [1024];
  logic        mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 + i;
      mem_init_done <= 1'b1;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (mem_ren[p]) mem_rdata[p*32 +: 32] <= mem[mem_raddr[p*10 +: 10]];
      end
      for (int i = 0; i < 3; i++) begin
        if (mem_wen[i]) mem[mem_waddr[i*10 +: 10]] <= mem_wdata[i*32 +: 32];
      end
    end
  end

  function automatic logic [31:0] init_val(input int a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rreq_vld = '0;
    wreq_vld = '0;
  endtask

  initial begin
    bp_exp = '{10, 11, 12, 31, 32, 33, 34, 35};
    rst = 1'b1; rreq_vld = '0; rreq_addr = '0; rrsp_rdy = '0;
    wreq_vld = '0; wreq_addr = '0; wreq_data = '0; mem_rdata = '0;
    tick();

    // Activity during reset must be blocked, including a 3-way collision.
    rreq_vld = 3'b111; rrsp_rdy = 3'b111;
    wreq_vld = 3'b111; wreq_addr = {3{10'd7}}; wreq_data = {32'h3, 32'h2, 32'h1};
    #1;
    chk("rst_rreq_rdy", rreq_rdy, 0);
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_rrsp_vld", rrsp_vld, 0);
    chk("rst_rrsp_data", rrsp_data, 0);
    tick();
    chk("rst_coll_cnt", wr_coll_cnt, 0);
    idle();
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", rreq_rdy, 3'b111);
    tick();

    // Write then read one cycle later.
    wreq_vld = 3'b001; wreq_addr = {20'd0, 10'd5}; wreq_data = {64'd0, 32'hDEADBEEF};
    #1 chk("wr_mem_wen", mem_wen, 3'b001);
    tick();
    idle();
    rreq_vld = 3'b001; rreq_addr = {20'd0, 10'd5};
    #1;
    chk("rd_mem_ren", mem_ren, 3'b001);
    chk("rd_mem_raddr", mem_raddr[9:0], 10'd5);
    tick();
    rreq_vld = '0;
    #1 chk("rd_vld_t1", rrsp_vld, 0);
    tick();
    chk("rd_vld_t2", rrsp_vld, 3'b001);
    chk("rd_data", rrsp_data[31:0], 32'hDEADBEEF);
    tick();
    chk("rd_popped", rrsp_vld, 0);

    // Streaming on all ports.
    for (int k = 0; k < 12; k++) begin
      rreq_vld  = (k < 8) ? 3'b111 : 3'b000;
      rreq_addr = {3{10'(k)}};
      #1;
      if (k < 8) chk("stream_rdy", rreq_rdy, 3'b111);
      if (k >= 2 && k < 10) begin
        chk("stream_vld", rrsp_vld, 3'b111);
        for (int p = 0; p < 3; p++) begin
          chk("stream_data", rrsp_data[p*32 +: 32],
              (k - 2 == 5) ? 32'hDEADBEEF : init_val(k - 2));
        end
      end
      tick();
    end
    chk("stream_drained", rrsp_vld, 0);

    // Backpressure on port 1.
    rrsp_rdy = 3'b101; rreq_vld = 3'b010;
    for (int k = 0; k < 6; k++) begin
      rreq_addr = {10'd0, 10'(10 + k), 10'd0};
      #1 chk("bp_rdy1", rreq_rdy[1], (k < 3));
      tick();
    end
    chk("bp_held_vld", rrsp_vld, 3'b010);
    rrsp_rdy = 3'b111;
    for (int r = 0; r < 9; r++) begin
      rreq_vld  = (r < 6) ? 3'b010 : 3'b000;
      rreq_addr = {10'd0, 10'(30 + r), 10'd0};
      #1;
      if (r < 6) chk("bp_rel_rdy1", rreq_rdy[1], (r != 0));
      if (r < 8) begin
        chk("bp_rel_vld", rrsp_vld, 3'b010);
        chk("bp_rel_data", rrsp_data[63:32], init_val(bp_exp[r]));
      end else begin
        chk("bp_drained", rrsp_vld, 0);
      end
      tick();
    end

    // Write collisions.
    wreq_vld = 3'b111; wreq_addr = {3{10'd9}}; wreq_data = {32'h3, 32'h2, 32'h1};
    #1;
    chk("coll3_wen", mem_wen, 3'b100);
    chk("coll3_waddr", mem_waddr, {3{10'd9}});
    chk("coll_cnt_pre", wr_coll_cnt, 0);
    tick();
    wreq_addr = {10'd41, 10'd40, 10'd40}; wreq_data = {32'h13, 32'h12, 32'h11};
    #1;
    chk("coll_cnt_2", wr_coll_cnt, 2);
    chk("coll01_wen", mem_wen, 3'b110);
    tick();
    wreq_vld = '0;
    rreq_vld = 3'b101; rreq_addr = {10'd9, 10'd0, 10'd40};
    #1 chk("coll_cnt_3", wr_coll_cnt, 3);
    tick();
    rreq_vld = '0;
    tick();
    chk("coll_rd_vld", rrsp_vld, 3'b101);
    chk("coll_rd9", rrsp_data[95:64], 32'h3);
    chk("coll_rd40", rrsp_data[31:0], 32'h12);
    tick();

    // Same-cycle write/read to the same address.
    wreq_vld = 3'b001; wreq_addr = {20'd0, 10'd3}; wreq_data = {64'd0, 32'hCAFE};
    rreq_vld = 3'b001; rreq_addr = {20'd0, 10'd3};
    tick();
    wreq_vld = 3'b011; wreq_addr = {10'd0, 10'd3, 10'd3};
    wreq_data = {32'd0, 32'hF00D, 32'hBAD};
    tick();
    wreq_vld = '0;
    #1;
    chk("byp1_vld", rrsp_vld, 3'b001);
`ifdef MP_RF_FRONTEND_BYPASS_EN
    chk("byp1_data", rrsp_data[31:0], 32'hCAFE);
`else
    chk("byp1_data", rrsp_data[31:0], init_val(3));
`endif
    tick();
    rreq_vld = '0;
    #1;
`ifdef MP_RF_FRONTEND_BYPASS_EN
    chk("byp2_data", rrsp_data[31:0], 32'hF00D);
`else
    chk("byp2_data", rrsp_data[31:0], 32'hCAFE);
`endif
    tick();
    chk("byp3_data", rrsp_data[31:0], 32'hF00D);
    tick();

    // Reset with reads in flight.
    rrsp_rdy = '0; rreq_vld = 3'b111; rreq_addr = {10'd7, 10'd6, 10'd4};
    #1 chk("mid_acc_rdy", rreq_rdy, 3'b111);
    tick();
    rreq_vld = '0; rst = 1'b1;
    #1 chk("mid_rst_rdy", rreq_rdy, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_post_rdy", rreq_rdy, 3'b111);
    chk("mid_post_cnt", wr_coll_cnt, 0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("mid_no_rsp", rrsp_vld, 0);
      tick();
    end
    rreq_vld = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1 chk("mid_credit_rdy", rreq_rdy, (k < 3) ? 3'b111 : 3'b000);
      tick();
    end
    rreq_vld = '0; rrsp_rdy = 3'b111;
    #1 chk("mid_drain_data", rrsp_data[31:0], init_val(4));
    for (int r = 0; r < 4; r++) begin
      #1 chk("mid_drain_vld", rrsp_vld, (r < 3) ? 3'b111 : 3'b000);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp_rf_frontend_3r3w.md
# mp_rf_frontend_3r3w

Request/response front-end that sits directly upstream of the 3-read/3-write flop-based LVT register-file memory and owns every one of its ports. Each read port gets a valid/ready request channel and a valid/ready response channel, with a credit-limited response FIFO that absorbs the memory's fixed, non-stallable read latency. Same-cycle write-port address collisions are resolved before the writes reach the memory, and an optional write-to-read bypass makes same-cycle writes visible to reads. Clients see a backpressurable register file; the memory sees only legal, collision-free enables.

## Interface
- NUM_R, 3, read ports
- NUM_W, 3, write ports
- W, 32, data width
- N, 1024, entries; AW = $clog2(N) = 10
- RSP_DEPTH, 3, response FIFO entries per read port; 3 is the minimum for 1 read/cycle/port
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- rreq_vld  in  NUM_R  read request valid, per port
- rreq_addr  in  NUM_R*AW  read address, per port
- rreq_rdy  out  NUM_R  read request ready, per port
- rrsp_vld  out  NUM_R  read response valid, per port
- rrsp_data  out  NUM_R*W  read response data, per port
- rrsp_rdy  in  NUM_R  read response ready, per port
- wreq_vld  in  NUM_W  write valid; writes are always accepted (no ready)
- wreq_addr  in  NUM_W*AW  write address
- wreq_data  in  NUM_W*W  write data
- mem_ren / mem_raddr  out  NUM_R / NUM_R*AW  memory read enable and address
- mem_rdata  in  NUM_R*W  memory read data, valid the cycle after mem_ren
- mem_wen / mem_waddr / mem_wdata  out  NUM_W / NUM_W*AW / NUM_W*W  memory write port
- wr_coll_cnt  out  16  saturating count of suppressed colliding writes

## Operation
- Read accept: rreq_vld & rreq_rdy at port p drives mem_ren[p] = 1 and mem_raddr[p] = rreq_addr[p] combinationally in the same cycle.
- Credits: per-port counter cr[p] in 0..RSP_DEPTH. It increments on accept and decrements on response pop (rrsp_vld & rrsp_rdy); both in one cycle leave it unchanged. rreq_rdy[p] = !rst & (cr[p] < RSP_DEPTH). No dependence on rreq_vld.
- Capture: one cycle after accept, mem_rdata[p] (or the bypass value) is pushed into the port-p FIFO. The credit scheme guarantees the FIFO never overflows. Overflow is an assertion failure.
- Response: rrsp_vld[p] = FIFO non-empty, and rrsp_data[p] = FIFO head (a registered value). Ordering is strict FIFO per port. Ports are fully independent.
- Write collision: if enabled write ports i < j share an address, the highest-numbered port wins. mem_wen[i] is forced to 0. wr_coll_cnt increments by the number of suppressed ports that cycle (0..2) and saturates at 16'hFFFF.
- mem_waddr/mem_wdata pass through unchanged. mem_wen = wreq_vld & ~suppressed.

## Timing
- Read latency: accept in cycle T gives rrsp_vld in T+2 (mem_rdata in T+1, FIFO write at the end of T+1).
- Throughput is 1 response/cycle/port sustained with RSP_DEPTH = 3 and rrsp_rdy held high.
- Write at T is visible through memory to reads accepted at T+1 or later.
- Reset values, and the values held while rst = 1: rreq_rdy = 0, rrsp_vld = 0, rrsp_data = 0, mem_ren = 0, mem_wen = 0, wr_coll_cnt = 0, all credits and FIFOs empty.
- Reset mid-operation: in-flight reads (accepted at T, with rst at T+1) are discarded and never appear. Memory contents are not cleared by this block.
- rreq_rdy first rises in the cycle after rst deasserts.

## Configuration
- MP_RF_FRONTEND_BYPASS_EN defined:
  - A read accepted at T whose address matches an effective (post-collision) write at T returns that write's data instead of mem_rdata.
  - The comparison is made at T and registered into a per-port bypass hit/data stage. The mux is applied at FIFO push in T+1.
  - Latency is unchanged.
- Undefined: that read returns the pre-write (old) memory contents, and no comparators or bypass flops exist.

## Structure
- Shared package mp_rf_frontend_pkg:
  - AW/W/N localparams and the port-count constants.
  - rd_req_t {addr}, wr_req_t {addr, data} and the credit counter type.
- One sub-module, mp_rf_rsp_fifo: a RSP_DEPTH-entry registered FIFO (push, pop, head, empty, full), instantiated once per read port in a generate loop.
- Collision resolution and bypass compare live inline in the top level.

## Test plan
- Reset then single read: write 0xDEADBEEF to addr 5 at T, read addr 5 on port 0 at T+1 -> rrsp_vld[0] at T+3 with data 0xDEADBEEF. rreq_rdy = 0 throughout reset.
- Streaming: ports 0–2 each issue 8 back-to-back reads to addrs 0..7 with rrsp_rdy = 1 -> 8 in-order responses per port on consecutive cycles, and rreq_rdy never drops.
- Backpressure: rrsp_rdy[1] = 0 with continuous requests -> exactly 3 accepts, then rreq_rdy[1] = 0. Release -> 3 responses drain in order and acceptance resumes, with no loss or duplication.
- Write collision: ports 0, 1 and 2 all write addr 9 with data 0x1, 0x2, 0x3 -> only mem_wen[2] high, a later read returns 0x3, and wr_coll_cnt = 2.
- Bypass (macro on): write 0xCAFE to addr 3 and read addr 3 in the same cycle -> response 0xCAFE. Macro off -> the old value is returned.
- Reset mid-flight: accept reads at T and assert rst at T+1 -> no rrsp_vld ever appears for them, and after reset all credits are at RSP_DEPTH availability.
